// File: rtl/maze_env_step.sv
// ============================================================================
//  Module      : maze_env_step
//  Description : Maze environment step engine. Accepts a move action,
//                resolves it against a 5x5 cell map and returns the new
//                agent cell, a signed reward and an episode-done flag.
//                Optional episode step limit: define MAZE_STEP_LIMIT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module maze_env_step #(
    parameter int START_STATE = 0,
    parameter int R_STEP      = -1,
    parameter int R_WALL      = -5,
    parameter int R_GOAL      = 10,
    parameter int R_TRAP      = -10,
    parameter int MAX_STEPS   = 50,
    parameter int STEP_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              map_wr_en,
    input  logic [4:0]        map_wr_addr,
    input  logic [3:0]        map_wr_data,
    input  logic              act_valid,
    output logic              act_ready,
    input  logic [1:0]        action,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [6:0]        current_state,
    output logic [7:0]        reward,
    output logic              done,
    output logic [STEP_W-1:0] step_count
);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_READY  = 3'd1;
    localparam logic [2:0] c_S_LOOKUP = 3'd2;
    localparam logic [2:0] c_S_RESP   = 3'd3;
    localparam logic [2:0] c_S_TERM   = 3'd4;

    localparam logic [3:0] c_CELL_WALL = 4'd2;
    localparam logic [3:0] c_CELL_GOAL = 4'd3;
    localparam logic [3:0] c_CELL_TRAP = 4'd4;

    localparam logic [7:0] c_R_STEP = 8'(R_STEP);
    localparam logic [7:0] c_R_WALL = 8'(R_WALL);
    localparam logic [7:0] c_R_GOAL = 8'(R_GOAL);
    localparam logic [7:0] c_R_TRAP = 8'(R_TRAP);

    localparam logic [2:0]        c_START_ROW = 3'(START_STATE / 5);
    localparam logic [2:0]        c_START_COL = 3'(START_STATE % 5);
    localparam logic [STEP_W-1:0] c_MAX_STEPS = STEP_W'(MAX_STEPS);
    localparam logic [STEP_W-1:0] c_STEP_ONE  = STEP_W'(1);

    logic [2:0]        r_state;
    logic [2:0]        w_next;

    // Agent position kept as row/col so move bounds are trivial compares
    logic [2:0]        r_row;
    logic [2:0]        r_col;
    logic [2:0]        r_tgt_row;
    logic [2:0]        r_tgt_col;
    logic              r_off;
    logic [7:0]        r_reward;
    logic              r_done;
    logic [STEP_W-1:0] r_step;

    logic [3:0]        r_map [0:24];

    logic [2:0]        w_nrow;
    logic [2:0]        w_ncol;
    logic              w_noff;
    logic [4:0]        w_cur_idx;
    logic [4:0]        w_tgt_idx;
    logic [3:0]        w_code;
    logic [STEP_W-1:0] w_step_inc;
    logic              w_limit;

    // row*5 + col without a multiplier
    assign w_cur_idx  = {r_row, 2'b00} + {2'b00, r_row} + {2'b00, r_col};
    assign w_tgt_idx  = {r_tgt_row, 2'b00} + {2'b00, r_tgt_row} + {2'b00, r_tgt_col};
    // Off-grid moves latch the current cell as target, so the index is always in range
    assign w_code     = r_map[w_tgt_idx];
    assign w_step_inc = (&r_step) ? r_step : r_step + c_STEP_ONE;

`ifdef MAZE_STEP_LIMIT_EN
    assign w_limit = (w_step_inc == c_MAX_STEPS);
`else
    logic w_unused_max;
    assign w_unused_max = ^c_MAX_STEPS;
    assign w_limit      = 1'b0;
`endif

    assign current_state = {2'b00, w_cur_idx};
    assign reward        = r_reward;
    assign done          = r_done;
    assign step_count    = r_step;

    // Target cell for the offered action; off-grid flags a blocked move
    always_comb begin
        w_nrow = r_row;
        w_ncol = r_col;
        w_noff = 1'b0;
        case (action)
            2'd0: if (r_row == 3'd0) w_noff = 1'b1; else w_nrow = r_row - 3'd1;
            2'd1: if (r_col == 3'd4) w_noff = 1'b1; else w_ncol = r_col + 3'd1;
            2'd2: if (r_row == 3'd4) w_noff = 1'b1; else w_nrow = r_row + 3'd1;
            default: if (r_col == 3'd0) w_noff = 1'b1; else w_ncol = r_col - 3'd1;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_S_IDLE;
        else     r_state <= w_next;
    end

    // FSM next state; start restarts the episode from any state
    always_comb begin
        w_next = r_state;
        if (start) begin
            w_next = c_S_READY;
        end else begin
            case (r_state)
                c_S_IDLE:   w_next = c_S_IDLE;
                c_S_READY:  if (act_valid) w_next = c_S_LOOKUP;
                c_S_LOOKUP: w_next = c_S_RESP;
                c_S_RESP:   if (resp_ready) w_next = r_done ? c_S_TERM : c_S_READY;
                c_S_TERM:   w_next = c_S_TERM;
                default:    w_next = c_S_IDLE;
            endcase
        end
    end

    // FSM outputs: handshakes are pure functions of the state
    always_comb begin
        act_ready  = (r_state == c_S_READY);
        resp_valid = (r_state == c_S_RESP);
    end

    // Episode datapath: position, target latch, reward, done and step count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row     <= c_START_ROW;
            r_col     <= c_START_COL;
            r_tgt_row <= c_START_ROW;
            r_tgt_col <= c_START_COL;
            r_off     <= 1'b0;
            r_reward  <= 8'd0;
            r_done    <= 1'b0;
            r_step    <= '0;
        end else if (start) begin
            r_row    <= c_START_ROW;
            r_col    <= c_START_COL;
            r_reward <= 8'd0;
            r_done   <= 1'b0;
            r_step   <= '0;
        end else if (r_state == c_S_READY) begin
            if (act_valid) begin
                r_tgt_row <= w_nrow;
                r_tgt_col <= w_ncol;
                r_off     <= w_noff;
            end
        end else if (r_state == c_S_LOOKUP) begin
            r_step <= w_step_inc;
            if (r_off || (w_code == c_CELL_WALL)) begin
                r_reward <= c_R_WALL;
                r_done   <= w_limit;
            end else begin
                r_row <= r_tgt_row;
                r_col <= r_tgt_col;
                case (w_code)
                    c_CELL_GOAL: begin
                        r_reward <= c_R_GOAL;
                        r_done   <= 1'b1;
                    end
                    c_CELL_TRAP: begin
                        r_reward <= c_R_TRAP;
                        r_done   <= 1'b1;
                    end
                    default: begin
                        r_reward <= c_R_STEP;
                        r_done   <= w_limit;
                    end
                endcase
            end
        end
    end

    // Cell map: written only while idle, never cleared by reset
    always_ff @(posedge clk) begin
        if ((r_state == c_S_IDLE) && map_wr_en && (map_wr_addr < 5'd25)) begin
            r_map[map_wr_addr] <= map_wr_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_maze_env_step.sv
// ============================================================================
//  Module      : tb_maze_env_step
//  Description : Scoreboard bench for maze_env_step. Stimulus pushes the
//                hand-computed response of each step; a monitor pops and
//                compares on every response handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_maze_env_step;

`ifdef MAZE_STEP_LIMIT_EN
    localparam bit LIM_EN = 1'b1;
`else
    localparam bit LIM_EN = 1'b0;
`endif
    localparam int MAX = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       map_wr_en = 1'b0;
    logic [4:0] map_wr_addr = 5'd0;
    logic [3:0] map_wr_data = 4'd0;
    logic       act_valid = 1'b0;
    logic       act_ready;
    logic [1:0] action = 2'd0;
    logic       resp_valid;
    logic       resp_ready = 1'b1;
    logic [6:0] current_state;
    logic [7:0] reward;
    logic       done;
    logic [7:0] step_count;

    maze_env_step #(.MAX_STEPS(MAX)) dut (
        .clk(clk), .rst(rst), .start(start),
        .map_wr_en(map_wr_en), .map_wr_addr(map_wr_addr), .map_wr_data(map_wr_data),
        .act_valid(act_valid), .act_ready(act_ready), .action(action),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .current_state(current_state), .reward(reward), .done(done),
        .step_count(step_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] st;
        logic [7:0] rw;
        logic       dn;
        logic [7:0] n;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic lim(input int n);
        return LIM_EN && (n == MAX);
    endfunction

    // Monitor: compare every accepted response against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resp_valid && resp_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_resp", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("resp_state", int'(current_state), int'(e.st));
                    chk("resp_reward", int'($signed(reward)), int'($signed(e.rw)));
                    chk("resp_done", int'(done), int'(e.dn));
                    chk("resp_steps", int'(step_count), int'(e.n));
                end
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wr_cell(input logic [4:0] a, input logic [3:0] d);
        @(posedge clk); #1;
        map_wr_en = 1'b1; map_wr_addr = a; map_wr_data = d;
        @(posedge clk); #1 map_wr_en = 1'b0;
    endtask

    task automatic wait_ready();
        int cnt = 0;
        while (!act_ready && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (!act_ready) chk("act_ready_timeout", 0, 1);
    endtask

    // Issue one action; result must be absent after accept edge, present one edge later
    task automatic do_step(input logic [1:0] a, input logic [4:0] es, input int er,
                           input logic ed, input int en);
        exp_t e;
        e.st = es; e.rw = 8'(er); e.dn = ed; e.n = 8'(en);
        q.push_back(e);
        wait_ready();
        act_valid = 1'b1; action = a;
        @(posedge clk); #1 act_valid = 1'b0;
        chk("lat_after_accept", int'(resp_valid), 0);
        @(posedge clk); #1;
        chk("lat_resp_valid", int'(resp_valid), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_act_ready", int'(act_ready), 0);
        chk("rst_resp_valid", int'(resp_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_state", int'(current_state), 0);
        chk("rst_reward", int'(reward), 0);
        chk("rst_steps", int'(step_count), 0);
        rst = 1'b0;

        // Map: 6 wall, 24 goal, 2 trap, 5 unknown code (free), 30 out of range
        wr_cell(5'd6, 4'd2);
        wr_cell(5'd24, 4'd3);
        wr_cell(5'd2, 4'd4);
        wr_cell(5'd5, 4'd7);
        wr_cell(5'd30, 4'd2);

        // Episode 1: free step, wall, trap
        pulse_start();
        do_step(2'd1, 5'd1, -1, 1'b0, 1);
        do_step(2'd2, 5'd1, -5, lim(2), 2);
        do_step(2'd1, 5'd2, -10, 1'b1, 3);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("term_act_ready", int'(act_ready), 0);
            chk("term_done", int'(done), 1);
        end

        // Episode 2: off-grid up and left, then down onto unknown-code cell
        pulse_start();
        chk("start_state", int'(current_state), 0);
        chk("start_steps", int'(step_count), 0);
        chk("start_done", int'(done), 0);
        chk("start_reward", int'(reward), 0);
        do_step(2'd0, 5'd0, -5, lim(1), 1);
        do_step(2'd3, 5'd0, -5, lim(2), 2);
        do_step(2'd2, 5'd5, -1, lim(3), 3);
        @(posedge clk); #1;
        chk("limit_act_ready", int'(act_ready), int'(!LIM_EN));

`ifndef MAZE_STEP_LIMIT_EN
        // Episode 3: walk to 19, then down into the goal
        pulse_start();
        do_step(2'd2, 5'd5, -1, 1'b0, 1);
        do_step(2'd2, 5'd10, -1, 1'b0, 2);
        do_step(2'd1, 5'd11, -1, 1'b0, 3);
        do_step(2'd1, 5'd12, -1, 1'b0, 4);
        do_step(2'd1, 5'd13, -1, 1'b0, 5);
        do_step(2'd1, 5'd14, -1, 1'b0, 6);
        do_step(2'd2, 5'd19, -1, 1'b0, 7);
        do_step(2'd2, 5'd24, 10, 1'b1, 8);
        repeat (3) @(posedge clk);
        #1;
        chk("goal_act_ready", int'(act_ready), 0);
        pulse_start();
        chk("goal_restart_state", int'(current_state), 0);
`endif

        // Episode 4: response stall, outputs must hold
        pulse_start();
        resp_ready = 1'b0;
        do_step(2'd1, 5'd1, -1, 1'b0, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_valid", int'(resp_valid), 1);
            chk("stall_act_ready", int'(act_ready), 0);
            chk("stall_state", int'(current_state), 1);
            chk("stall_reward", int'($signed(reward)), -1);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;

        // Reset during LOOKUP discards the pending action
        wait_ready();
        act_valid = 1'b1; action = 2'd2;
        @(posedge clk); #1 act_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_resp_valid", int'(resp_valid), 0);
        chk("midrst_state", int'(current_state), 0);
        chk("midrst_act_ready", int'(act_ready), 0);
        @(posedge clk); #1 rst = 1'b0;

        // Map survives reset: wall below cell 1 still blocks
        pulse_start();
        do_step(2'd1, 5'd1, -1, 1'b0, 1);
        do_step(2'd2, 5'd1, -5, lim(2), 2);

        cnt = 0;
        while (q.size() != 0 && cnt < 20) begin
            @(posedge clk);
            cnt++;
        end
        chk("queue_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
